imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time writer for the byte-addressed, big-endian instruction memory. Accepts a framed byte stream (length, payload, checksum) over a valid/ready interface and assembles big-endian 32-bit words. Issues one word write per instruction into the memory's write port, while holding the ARM core in reset until a valid image is loaded. Sits between the host/UART byte receiver and the instruction memory's write side.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes; max image = MEM_BYTES/4 words
BASE_ADDR, 0, byte address of first written word (word aligned)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  re-arm pulse; honoured only in DONE or ERR
in_valid  in  1  byte stream valid
in_data  in  8  byte stream data
in_ready  out  1  loader accepts byte when in_valid && in_ready
wr_en  out  1  one-cycle word write strobe to instruction memory
wr_addr  out  32  byte address of word (mem bytes addr..addr+3)
wr_data  out  32  word; [31:24]->addr, [23:16]->addr+1, [15:8]->addr+2, [7:0]->addr+3
cpu_hold  out  1  1 = keep core in reset
done  out  1  image loaded and checksum good (level)
error  out  1  length overflow or checksum mismatch (level)

Behaviour:
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), 4*N payload bytes (MSB first per word), 1 checksum byte = XOR of all payload bytes (length bytes excluded).
- Reset values: in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, error=0; FSM=IDLE; counters and checksum cleared.
- FSM states: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERR.
- IDLE -> LEN_HI unconditionally on the next cycle (auto-arm after reset).
- LEN_HI/LEN_LO/PAYLOAD/CHECK: in_ready=1; state advances only on a handshake. Gaps (in_valid=0) stall with no state change.
- LEN_LO handshake: N>MEM_BYTES/4 -> ERR; N==0 -> CHECK; else -> PAYLOAD with word count=N, byte index=0, wr_addr=BASE_ADDR.
- PAYLOAD: each accepted byte is shifted into the word register and XORed into the checksum. On the 4th byte of a word, the cycle after that handshake has wr_en=1 with the full word on wr_data and the current wr_addr (1-cycle latency). The following cycle wr_addr += 4. After the Nth word's 4th byte -> CHECK.
- CHECK handshake: byte==checksum -> DONE, else -> ERR.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERR: error=1, cpu_hold=1, in_ready=0. Memory contents already written are not rolled back.
- start in DONE/ERR: clear done/error/checksum, set cpu_hold=1, go to LEN_HI next cycle. start in any other state is ignored.
- The memory write port never backpressures. At most one wr_en per 4 accepted bytes, so back-to-back words at full rate are legal.
- rst mid-frame: return to reset values next cycle. A partially assembled word is discarded and no wr_en is issued for it.
- wr_addr arithmetic is 32-bit. The overflow check guarantees wr_addr+3 < BASE_ADDR+MEM_BYTES for BASE_ADDR=0.

Decomposition:
- Shared package holds the FSM state enum, the frame constants (LEN_BYTES=2, BYTES_PER_WORD=4) and the big-endian byte-lane mapping used by both the instruction memory and this loader.
- One natural sub-module: imem_word_packer (byte shift register + lane counter + XOR accumulator, word_valid pulse), instantiated by the FSM top.

Test Plan:
- Bytes 00 02 E3 A0 00 14 E3 A0 1A 01 0F at full rate -> wr_en pulses with (0x0, 0xE3A00014) and (0x4, 0xE3A01A01), each one cycle after the 4th byte; then done=1, cpu_hold=0, error=0.
- Same frame with checksum byte 0x10 -> both writes still occur; error=1, done=0, cpu_hold=1, in_ready=0.
- Length 01 01 (257 words, MEM_BYTES=1024) -> ERR immediately after LEN_LO; no wr_en; in_ready=0.
- Length 00 00, checksum 00 -> done=1 with zero writes. Same with checksum 01 -> error=1.
- First frame with in_valid toggled randomly (1–3 idle cycles between bytes) -> identical writes and done as the full-rate case.
- rst asserted after the 2nd payload byte -> no write, cpu_hold=1, FSM reaches LEN_HI. Reload of the first frame -> done=1. Then start in DONE -> done=0, cpu_hold=1, awaits new length.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// frame constants and the big-endian byte-lane mapping of the instruction memory.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_PAYLOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);

   // Byte at address (word_addr + lane) lives in bits [31-8*lane -: 8].
   function automatic logic [31:0] be_insert(input logic [31:0]       word,
                                             input logic [LANE_W-1:0] lane,
                                             input logic [7:0]        b);
      logic [31:0] w;
      w = word;
      w[8*(BYTES_PER_WORD-1-int'(lane)) +: 8] = b;
      return w;
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles accepted payload bytes into big-endian words, keeps the running
// XOR checksum and pulses word_valid_o the cycle after a word completes.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              byte_vld_i,
   input  logic [7:0]        byte_i,
   output logic              last_byte_o,
   output logic              word_valid_o,
   output logic [31:0]       word_o,
   output logic [7:0]        csum_o
);

   logic [LANE_W-1:0] lane_q;
   logic [31:0]       word_q;
   logic [7:0]        csum_q;
   logic              word_valid_q;

   assign last_byte_o = byte_vld_i && (lane_q == LANE_W'(BYTES_PER_WORD-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q       <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= last_byte_o;
         if (clr_i) begin
            lane_q <= '0;
            csum_q <= '0;
         end else if (byte_vld_i) begin
            lane_q <= lane_q + 1'b1;
            word_q <= be_insert(word_q, lane_q, byte_i);
            csum_q <= csum_q ^ byte_i;
         end
      end
   end

   assign word_valid_o = word_valid_q;
   assign word_o       = word_q;
   assign csum_o       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/payload/checksum byte frame, writes words
// into the instruction memory and holds the core in reset until the image checks out.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          MEM_BYTES = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int LEN_W = 8*LEN_BYTES;
   localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(MEM_BYTES/BYTES_PER_WORD);

   state_e           state_q, state_d;
   logic [7:0]       len_hi_q;
   logic [LEN_W-1:0] words_q;
   logic [31:0]      addr_q;

   logic             hs, clr, pk_vld, last_byte, word_valid;
   logic [7:0]       csum;
   logic [LEN_W-1:0] n_len;

   assign hs    = in_valid && in_ready;
   assign n_len = {len_hi_q, in_data};

   imem_word_packer u_packer (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr),
      .byte_vld_i  (pk_vld),
      .byte_i      (in_data),
      .last_byte_o (last_byte),
      .word_valid_o(word_valid),
      .word_o      (wr_data),
      .csum_o      (csum)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      clr      = 1'b0;
      pk_vld   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            clr     = 1'b1;
            state_d = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            in_ready = 1'b1;
            if (hs) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            in_ready = 1'b1;
            if (hs) begin
               if ({1'b0, n_len} > MAX_WORDS) state_d = ST_ERR;
               else if (n_len == '0)          state_d = ST_CHECK;
               else                           state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            in_ready = 1'b1;
            pk_vld   = hs;
            if (last_byte && words_q == LEN_W'(1)) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            in_ready = 1'b1;
            if (hs) state_d = (in_data == csum) ? ST_DONE : ST_ERR;
         end
         ST_DONE, ST_ERR: begin
            if (start) begin
               clr     = 1'b1;
               state_d = ST_LEN_HI;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Address advances the cycle after the write strobe, so wr_en sees the old address.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi_q <= '0;
         words_q  <= '0;
         addr_q   <= BASE_ADDR;
      end else begin
         if (state_q == ST_LEN_HI && hs) len_hi_q <= in_data;
         if (state_q == ST_LEN_LO && hs) begin
            words_q <= n_len;
            addr_q  <= BASE_ADDR;
         end else begin
            if (last_byte)  words_q <= words_q - 1'b1;
            if (word_valid) addr_q  <= addr_q + 32'd4;
         end
      end
   end

   assign wr_en    = word_valid;
   assign wr_addr  = addr_q;
   assign done     = (state_q == ST_DONE);
   assign error    = (state_q == ST_ERR);
   assign cpu_hold = (state_q != ST_DONE);

endmodule
